// File: rtl/sfp_vec_rgb_packer.sv
// Clamp/quantize signed fixed-point colours to RGB888 and emit a raster stream.
// Two-stage valid/ready pipeline (S1 quantized bytes, S2 output) with x/y counters.
//
// Ports:
//   clk, rst (sync, active-high), clear (sync flush of pipeline and counters)
//   in_valid/in_ready/in_col    : colour input, {B,G,R} each IW+QW two's complement
//   out_valid/out_ready         : pixel output handshake
//   out_pixel                   : {R,G,B} bytes
//   out_sof/out_eol/out_eof     : raster flags of the presented pixel
module sfp_vec_rgb_packer #(
   parameter int IW     = 4,
   parameter int QW     = 12,
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3*(IW+QW)-1:0]   in_col,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [23:0]            out_pixel,
   output logic                   out_sof,
   output logic                   out_eol,
   output logic                   out_eof
);

   localparam int W  = IW + QW;
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   localparam logic [W:0]    RND    = (W+1)'(1) << (QW - 9);
   localparam logic [W:0]    SAT    = (W+1)'(255);
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   generate
      if (QW < 9) begin : g_bad_qw
         $error("sfp_vec_rgb_packer: QW must be >= 9");
      end
      if (WIDTH < 2) begin : g_bad_w
         $error("sfp_vec_rgb_packer: WIDTH must be >= 2");
      end
      if (HEIGHT < 2) begin : g_bad_h
         $error("sfp_vec_rgb_packer: HEIGHT must be >= 2");
      end
   endgenerate

   // Round-half-up to 8 fraction bits; one extra bit keeps c + RND from overflowing.
   function automatic logic [7:0] f_quant(input logic [W-1:0] c);
      logic [W:0] t;
      t = ({1'b0, c} + RND) >> (QW - 8);
      if (c[W-1])
         f_quant = 8'd0;
      else if (t > SAT)
         f_quant = 8'hFF;
      else
         f_quant = t[7:0];
   endfunction

   logic          r_s1_v;
   logic [23:0]   r_s1_pix;
   logic          r_s2_v;
   logic [23:0]   r_s2_pix;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;

   logic          w_s2_adv;
   logic          w_s2_open;
   logic          w_s1_adv;
   logic          w_in_fire;
   logic [23:0]   w_q;

   assign w_q = {f_quant(in_col[W-1:0]),
                 f_quant(in_col[2*W-1:W]),
                 f_quant(in_col[3*W-1:2*W])};

   assign w_s2_adv  = r_s2_v & out_ready;
   assign w_s2_open = ~r_s2_v | w_s2_adv;
   assign w_s1_adv  = r_s1_v & w_s2_open;
   assign in_ready  = ~r_s1_v | w_s1_adv;
   assign w_in_fire = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_v   <= 1'b0;
         r_s1_pix <= '0;
         r_s2_v   <= 1'b0;
         r_s2_pix <= '0;
         r_x      <= '0;
         r_y      <= '0;
      end else if (clear) begin
         r_s1_v <= 1'b0;
         r_s2_v <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
      end else begin
         if (in_ready)
            r_s1_v <= in_valid;
         if (w_in_fire)
            r_s1_pix <= w_q;
         if (w_s2_open)
            r_s2_v <= r_s1_v;
         if (w_s1_adv)
            r_s2_pix <= r_s1_pix;
         if (w_s2_adv) begin
            if (r_x == X_LAST) begin
               r_x <= '0;
               r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
         end
      end
   end

   // Flags come from the counters of the presented pixel, gated so idle reads 0.
   assign out_valid = r_s2_v;
   assign out_pixel = r_s2_pix;
   assign out_sof   = r_s2_v & (r_x == '0) & (r_y == '0);
   assign out_eol   = r_s2_v & (r_x == X_LAST);
   assign out_eof   = r_s2_v & (r_x == X_LAST) & (r_y == Y_LAST);

endmodule
